// File: rtl/ft245_tx.sv
// Frames 16-bit pixels (optional A5/5A line header) into a byte FIFO and writes them to an FT245, one byte per 9 cycles.
// s_ready drops when fewer than 4 bytes are free; writes stall while synchronised TXE# is high.
module ft245_tx #(
  parameter int          FIFO_AW  = 8,
  parameter int          WR_CYC   = 3,
  parameter int          HOLD_CYC = 1,
  parameter int          GAP_CYC  = 4,
  parameter logic [7:0]  HDR0     = 8'hA5,
  parameter logic [7:0]  HDR1     = 8'h5A
) (
  input  logic        clk,
  input  logic        RST_N,
  input  logic        s_valid,
  input  logic [15:0] s_data,
  input  logic        s_sof,
  output logic        s_ready,
  output logic [7:0]  FT_D_OUT,
  output logic        FT_D_OE,
  output logic        FT_WR,
  input  logic        FT_TXE,
  output logic        busy
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, GAP} state_t;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic [FIFO_AW:0]   free;
  logic [7:0]         stg [4];
  logic [2:0]         n_push;
  logic               accept, pop;
  logic               txe_m, txe_s;
  state_t             state;
  logic [7:0]         cyc;

  assign free    = (FIFO_AW+1)'(DEPTH) - count;
  assign s_ready = (free >= (FIFO_AW+1)'(4));
  assign accept  = s_valid & s_ready;
  assign pop     = (state == SETUP) && (cyc == 8'(WR_CYC - 1));

  // Staging: bytes in push order, MSB of the pixel first.
  always_comb begin
    for (int i = 0; i < 4; i++) stg[i] = 8'h00;
    n_push = 3'd0;
    if (accept) begin
      if (s_sof) begin
        stg[0] = HDR0;
        stg[1] = HDR1;
        stg[2] = s_data[15:8];
        stg[3] = s_data[7:0];
        n_push = 3'd4;
      end else begin
        stg[0] = s_data[15:8];
        stg[1] = s_data[7:0];
        n_push = 3'd2;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (3'(i) < n_push) mem[wr_ptr + FIFO_AW'(i)] <= stg[i];
    end
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      busy   <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + FIFO_AW'(n_push);
      rd_ptr <= rd_ptr + FIFO_AW'(pop);
      count  <= count + (FIFO_AW+1)'(n_push) - (FIFO_AW+1)'(pop);
      busy   <= (count != '0) || (state != IDLE);
    end
  end

  // TXE# is asynchronous to clk; preset to "not ready" so nothing starts out of reset.
  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      txe_m <= 1'b1;
      txe_s <= 1'b1;
    end else begin
      txe_m <= FT_TXE;
      txe_s <= txe_m;
    end
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      cyc      <= 8'd0;
      FT_WR    <= 1'b0;
      FT_D_OE  <= 1'b0;
      FT_D_OUT <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if ((count != '0) && !txe_s) begin
            state    <= SETUP;
            FT_D_OUT <= mem[rd_ptr];
            FT_D_OE  <= 1'b1;
            FT_WR    <= 1'b1;
            cyc      <= 8'd0;
          end
        end
        SETUP: begin
          // Committed once started: a late TXE# rise does not abort the strobe.
          if (cyc == 8'(WR_CYC - 1)) begin
            state <= STROBE;
            FT_WR <= 1'b0;
            cyc   <= 8'd0;
          end else begin
            cyc <= cyc + 8'd1;
          end
        end
        STROBE: begin
          if (cyc == 8'(HOLD_CYC - 1)) begin
            state   <= GAP;
            FT_D_OE <= 1'b0;
            cyc     <= 8'd0;
          end else begin
            cyc <= cyc + 8'd1;
          end
        end
        GAP: begin
          if (cyc == 8'(GAP_CYC - 1)) begin
            state <= IDLE;
            cyc   <= 8'd0;
          end else begin
            cyc <= cyc + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ft245_tx.sv
// Randomised bench for ft245_tx against a byte-queue reference model.
module tb_ft245_tx;

  logic        clk = 1'b0;
  logic        RST_N;
  logic        s_valid, s_sof, s_ready;
  logic [15:0] s_data;
  logic [7:0]  FT_D_OUT;
  logic        FT_D_OE, FT_WR, FT_TXE, busy;

  always #10 clk = ~clk;

  ft245_tx dut (
    .clk      (clk),
    .RST_N    (RST_N),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_sof    (s_sof),
    .s_ready  (s_ready),
    .FT_D_OUT (FT_D_OUT),
    .FT_D_OE  (FT_D_OE),
    .FT_WR    (FT_WR),
    .FT_TXE   (FT_TXE),
    .busy     (busy)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  int         ncyc    = 0;
  logic [7:0] q[$];
  int         falls[$];
  logic       prev_wr = 1'b0;
  logic       tb_s1 = 1'b1, tb_s2 = 1'b1;
  logic       acc, fell;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, ncyc);
    end
  endtask

  // One clock: drive inputs, let the edge pass, then update the model and compare.
  task automatic cyc(input logic v, input logic sof, input logic [15:0] d, input logic txe);
    logic rdy_b, s2_b;
    logic [7:0] exp_b;
    rdy_b   = s_ready;
    s2_b    = tb_s2;
    s_valid = v;
    s_sof   = sof;
    s_data  = d;
    FT_TXE  = txe;
    @(posedge clk);
    @(negedge clk);
    ncyc++;
    acc  = v && rdy_b;
    fell = prev_wr && !FT_WR;
    if (acc) begin
      if (sof) begin
        q.push_back(8'hA5);
        q.push_back(8'h5A);
      end
      q.push_back(d[15:8]);
      q.push_back(d[7:0]);
    end
    if (fell) begin
      check("wr_expected", 32'(q.size() > 0), 32'd1);
      check("oe_at_strobe", FT_D_OE, 1'b1);
      if (q.size() > 0) begin
        exp_b = q.pop_front();
        check("byte", FT_D_OUT, exp_b);
      end
      falls.push_back(ncyc);
    end
    if (!prev_wr && FT_WR) check("wr_start_txe", s2_b, 1'b0);
    tb_s2   = tb_s1;
    tb_s1   = txe;
    prev_wr = FT_WR;
    check("s_ready", s_ready, 32'((256 - q.size()) >= 4));
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (q.size() > 0 && n < bound) begin
      cyc(1'b0, 1'b0, 16'h0, 1'b0);
      n++;
    end
    check("drain_done", q.size(), 0);
    repeat (12) cyc(1'b0, 1'b0, 16'h0, 1'b0);
    check("idle_busy", busy, 1'b0);
    check("idle_oe", FT_D_OE, 1'b0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0; s_valid = 1'b0; s_sof = 1'b0; s_data = 16'h0; FT_TXE = 1'b0;
    #25;
    check("rst_wr", FT_WR, 1'b0);
    check("rst_oe", FT_D_OE, 1'b0);
    check("rst_dout", FT_D_OUT, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_ready", s_ready, 1'b1);
    @(negedge clk);
    RST_N = 1'b1;

    // Single framed pixel: header plus two data bytes, 9 cycles apart.
    falls.delete();
    cyc(1'b1, 1'b1, 16'h1234, 1'b0);
    drain(200);
    check("t1_nbytes", falls.size(), 4);
    if (falls.size() >= 4)
      for (int i = 1; i < 4; i++) check("t1_spacing", falls[i] - falls[i-1], 9);

    // Unframed pixels.
    cyc(1'b1, 1'b0, 16'hABCD, 1'b0);
    cyc(1'b1, 1'b0, 16'h0001, 1'b0);
    drain(200);

    // Fill to 256 bytes with TXE# held high.
    repeat (4) cyc(1'b0, 1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 126; i++) cyc(1'b1, 1'b0, 16'($urandom), 1'b1);
    cyc(1'b1, 1'b1, 16'($urandom), 1'b1);
    check("t3_full_rdy", s_ready, 1'b0);
    repeat (40) begin
      cyc(1'b1, 1'b0, 16'h7777, 1'b1);
      check("t3_wr_held", FT_WR, 1'b0);
    end
    drain(3000);
    check("t3_rdy_back", s_ready, 1'b1);

    // 1500-pixel line with TXE# pulsed high after every write.
    begin
      int pix, hi, guard;
      logic [15:0] d;
      logic txe_v;
      pix = 0; hi = 0; guard = 0; d = 16'($urandom);
      while ((pix < 1500 || q.size() > 0) && guard < 45000) begin
        txe_v = (hi > 0);
        if (hi > 0) hi--;
        cyc(pix < 1500, pix == 0, d, txe_v);
        if (acc) begin
          pix++;
          d = 16'($urandom);
        end
        if (fell) hi = 3;
        guard++;
      end
      check("t4_pixels", pix, 1500);
      drain(200);
    end

    // Continuous offered load with random framing.
    begin
      logic [15:0] d;
      logic sof;
      d = 16'($urandom); sof = 1'b1;
      repeat (3000) begin
        cyc(1'b1, sof, d, 1'b0);
        if (acc) begin
          d   = 16'($urandom);
          sof = ($urandom_range(7) == 0);
        end
      end
      drain(3000);
    end

    // Reset during SETUP.
    begin
      int n;
      cyc(1'b1, 1'b1, 16'hBEEF, 1'b0);
      cyc(1'b1, 1'b0, 16'h5555, 1'b0);
      n = 0;
      while (!FT_WR && n < 30) begin
        cyc(1'b0, 1'b0, 16'h0, 1'b0);
        n++;
      end
      check("t6_in_setup", FT_WR, 1'b1);
      #5;
      RST_N = 1'b0;
      #1;
      check("t6_wr", FT_WR, 1'b0);
      check("t6_oe", FT_D_OE, 1'b0);
      check("t6_busy", busy, 1'b0);
      check("t6_ready", s_ready, 1'b1);
      @(negedge clk);
      RST_N = 1'b1;
      q.delete();
      prev_wr = 1'b0; tb_s1 = 1'b1; tb_s2 = 1'b1;
      repeat (20) cyc(1'b0, 1'b0, 16'h0, 1'b0);
      check("t6_post_wr", FT_WR, 1'b0);
      check("t6_post_busy", busy, 1'b0);
      check("t6_post_ready", s_ready, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
